// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_C    = 2'b01;
   localparam logic [1:0] GRANT_X    = 2'b10;

   localparam int MEM_ARB_MAX_WAIT = 15;

   // X wins when it asks alone, or on contention when X is the preferred side.
   function automatic logic pick_x(input logic c_req, input logic x_req, input logic prefer_x);
      return x_req & (~c_req | prefer_x);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_reg32.sv
// rtl/mem_bus_arbiter_reg32.sv - 32-bit enabled holding register with async active-low reset
module mem_bus_arbiter_reg32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] data_d;
   logic [31:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en) data_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (CPU/aux) arbiter for a single-ported memory with fixed wait states
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the CPU port always wins.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic              iClk,
   input  logic              nRst,
   input  logic              iC_Read,
   input  logic              iC_Write,
   input  logic [ADDR_W-1:0] iC_Addr,
   input  logic [31:0]       iC_WData,
   output logic [31:0]       oC_RData,
   output logic              oC_Rdy,
   input  logic              iX_Read,
   input  logic              iX_Write,
   input  logic [ADDR_W-1:0] iX_Addr,
   input  logic [31:0]       iX_WData,
   output logic [31:0]       oX_RData,
   output logic              oX_Rdy,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [31:0]       oMemWData,
   output logic              oMemRead,
   output logic              oMemWrite,
   input  logic [31:0]       iMemRData,
   output logic [1:0]        oGrant
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   arb_state_e        state_d, state_q;
   logic [1:0]        grant_d, grant_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [31:0]       wdata_d, wdata_q;
   logic              wr_d, wr_q;
   logic [3:0]        cnt_d, cnt_q;

   logic c_req, x_req, win_x, prefer_x;
   logic rd_done_c, rd_done_x;

   assign c_req = iC_Read | iC_Write;
   assign x_req = iX_Read | iX_Write;

`ifdef MEM_ARB_RR_EN
   logic last_x_d, last_x_q;

   assign prefer_x = ~last_x_q;

   always_comb begin
      last_x_d = last_x_q;
      if (state_q == ST_IDLE && (c_req | x_req)) last_x_d = win_x;
   end

   // Resets to X so that the first contention goes to the CPU.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) last_x_q <= 1'b1;
      else       last_x_q <= last_x_d;
   end
`else
   assign prefer_x = 1'b0;
`endif

   assign win_x = pick_x(c_req, x_req, prefer_x);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      rd_done_c = 1'b0;
      rd_done_x = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (c_req | x_req) begin
               grant_d = win_x ? GRANT_X : GRANT_C;
               addr_d  = win_x ? iX_Addr : iC_Addr;
               wdata_d = win_x ? iX_WData : iC_WData;
               wr_d    = win_x ? iX_Write : iC_Write;
               cnt_d   = WAIT_CNT;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               rd_done_c = ~wr_q & grant_q[0];
               rd_done_x = ~wr_q & grant_q[1];
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            grant_d = GRANT_NONE;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = GRANT_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         grant_q <= GRANT_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   mem_bus_arbiter_reg32 u_c_rdata (
      .clk   (iClk),
      .rst_n (nRst),
      .en    (rd_done_c),
      .d     (iMemRData),
      .q     (oC_RData)
   );

   mem_bus_arbiter_reg32 u_x_rdata (
      .clk   (iClk),
      .rst_n (nRst),
      .en    (rd_done_x),
      .d     (iMemRData),
      .q     (oX_RData)
   );

   // Ready is high for an idle port and for exactly the DONE cycle of its own access.
   assign oC_Rdy    = ~c_req | (state_q == ST_DONE && grant_q[0]);
   assign oX_Rdy    = ~x_req | (state_q == ST_DONE && grant_q[1]);
   assign oGrant    = grant_q;
   assign oMemAddr  = addr_q;
   assign oMemWData = wdata_q;
   assign oMemRead  = (state_q == ST_ACCESS) & ~wr_q;
   assign oMemWrite = (state_q == ST_ACCESS) & wr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized bench for mem_bus_arbiter at wait states 0, 1 and 15
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a * 32'h9E3779B1 + 32'h01357BDF;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 15;

      logic        rst_n;
      logic        c_rd, c_wr, x_rd, x_wr;
      logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
      logic [31:0] c_rdata, x_rdata, mem_addr, mem_wdata, mem_rdata;
      logic        c_rdy, x_rdy, mem_rd, mem_wr;
      logic [1:0]  grant;
      bit          finished = 1'b0;

      assign mem_rdata = mem_val(mem_addr);

      mem_bus_arbiter #(.ADDR_W(32), .WAIT_STATES(W)) dut (
         .iClk      (clk),
         .nRst      (rst_n),
         .iC_Read   (c_rd),
         .iC_Write  (c_wr),
         .iC_Addr   (c_addr),
         .iC_WData  (c_wdata),
         .oC_RData  (c_rdata),
         .oC_Rdy    (c_rdy),
         .iX_Read   (x_rd),
         .iX_Write  (x_wr),
         .iX_Addr   (x_addr),
         .iX_WData  (x_wdata),
         .oX_RData  (x_rdata),
         .oX_Rdy    (x_rdy),
         .oMemAddr  (mem_addr),
         .oMemWData (mem_wdata),
         .oMemRead  (mem_rd),
         .oMemWrite (mem_wr),
         .iMemRData (mem_rdata),
         .oGrant    (grant)
      );

      initial begin : run
         int          n, s, next_ok, ph, k;
         bit          act, own_x, m_wr, last_x, in_acc, in_done, done_c, done_x, creq, xreq;
         logic [31:0] m_addr, m_wdata;
         logic [31:0] exp_rd [0:1];
         logic [1:0]  exp_g;
         string       p;

         p = $sformatf("w%0d_", W);
         rst_n = 1'b0;
         {c_rd, c_wr, x_rd, x_wr} = 4'b0;
         c_addr = '0; c_wdata = '0; x_addr = '0; x_wdata = '0;
         repeat (2) @(negedge clk);
         check_val({p, "rst_grant"}, {30'd0, grant}, 32'd0);
         check_val({p, "rst_strobes"}, {30'd0, mem_rd, mem_wr}, 32'd0);
         check_val({p, "rst_addr"}, mem_addr, 32'd0);
         check_val({p, "rst_wdata"}, mem_wdata, 32'd0);
         check_val({p, "rst_rdata"}, c_rdata | x_rdata, 32'd0);
         check_val({p, "rst_rdy"}, {30'd0, c_rdy, x_rdy}, 32'd3);

         // Start a read, then pull reset in the middle of its access phase.
         rst_n  = 1'b1;
         c_rd   = 1'b1;
         c_addr = 32'h10;
         @(posedge clk);
         @(negedge clk);
         check_val({p, "pre_rst_read"}, {30'd0, mem_rd, mem_wr}, 32'd2);
         check_val({p, "pre_rst_grant"}, {30'd0, grant}, 32'd1);
         check_val({p, "pre_rst_addr"}, mem_addr, 32'h10);
         #2;
         rst_n = 1'b0;
         c_rd  = 1'b0;
         #1;
         check_val({p, "async_rst_strobes"}, {30'd0, mem_rd, mem_wr}, 32'd0);
         check_val({p, "async_rst_grant"}, {30'd0, grant}, 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (3) begin
            @(negedge clk);
            check_val({p, "idle_grant"}, {30'd0, grant}, 32'd0);
            check_val({p, "idle_rdy"}, {30'd0, c_rdy, x_rdy}, 32'd3);
            check_val({p, "aborted_rdata"}, c_rdata, 32'd0);
         end

         n = 0; s = 0; next_ok = 0; act = 0; own_x = 0; m_wr = 0; last_x = 1;
         m_addr = '0; m_wdata = '0;
         exp_rd[0] = '0; exp_rd[1] = '0;
         done_c = 0; done_x = 0;

         for (int cyc = 0; cyc < 320; cyc++) begin
            if (done_c) {c_rd, c_wr} = 2'b00;
            if (done_x) {x_rd, x_wr} = 2'b00;
            if (!(c_rd | c_wr) && cyc < 300 && $urandom_range(0, 2) != 0) begin
               k = $urandom_range(0, 3);
               c_rd = (k != 1); c_wr = (k == 1 || k == 2);
               c_addr = $urandom; c_wdata = $urandom;
            end
            if (!(x_rd | x_wr) && cyc < 300 && $urandom_range(0, 2) != 0) begin
               k = $urandom_range(0, 3);
               x_rd = (k != 1); x_wr = (k == 1 || k == 2);
               x_addr = $urandom; x_wdata = $urandom;
            end

            @(posedge clk);
            creq = c_rd | c_wr;
            xreq = x_rd | x_wr;
            n++;
            if (act && n == s + W + 1 && !m_wr) exp_rd[own_x] = mem_val(m_addr);
            if (n >= next_ok && (creq || xreq)) begin
`ifdef MEM_ARB_RR_EN
               own_x = xreq && (!creq || !last_x);
`else
               own_x = xreq && !creq;
`endif
               last_x  = own_x;
               act     = 1;
               s       = n;
               next_ok = n + W + 3;
               m_wr    = own_x ? x_wr : c_wr;
               m_addr  = own_x ? x_addr : c_addr;
               m_wdata = own_x ? x_wdata : c_wdata;
            end

            @(negedge clk);
            ph      = n - s;
            in_acc  = act && ph <= W;
            in_done = act && ph == W + 1;
            exp_g   = (in_acc || in_done) ? (own_x ? 2'b10 : 2'b01) : 2'b00;
            done_c  = in_done && !own_x;
            done_x  = in_done && own_x;
            check_val({p, "grant"}, {30'd0, grant}, {30'd0, exp_g});
            check_val({p, "mem_read"}, {31'd0, mem_rd}, {31'd0, in_acc && !m_wr});
            check_val({p, "mem_write"}, {31'd0, mem_wr}, {31'd0, in_acc && m_wr});
            if (in_acc) check_val({p, "mem_addr"}, mem_addr, m_addr);
            if (in_acc && m_wr) check_val({p, "mem_wdata"}, mem_wdata, m_wdata);
            check_val({p, "c_rdy"}, {31'd0, c_rdy}, {31'd0, !(c_rd | c_wr) || done_c});
            check_val({p, "x_rdy"}, {31'd0, x_rdy}, {31'd0, !(x_rd | x_wr) || done_x});
            check_val({p, "c_rdata"}, c_rdata, exp_rd[0]);
            check_val({p, "x_rdata"}, x_rdata, exp_rd[1]);
         end
         finished = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         if (g_inst[0].finished && g_inst[1].finished && g_inst[2].finished) break;
      end
      check_val("all_done",
                {29'd0, g_inst[2].finished, g_inst[1].finished, g_inst[0].finished}, 32'd7);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
